stopwatch_ctrl: RTL

Control FSM for the stopwatch datapath, running on the 100 Hz system tick. It is the parametrised successor of the single-bit pause/resume toggle. It decodes two debounced one-pulse button streams, start/stop and lap/reset, into four modes: idle, run, pause and lap-freeze. It also detects a long press on the lap button to issue a synchronous clear to the BCD counters.

---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/long_press.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared encodings and constants for the stopwatch control slice
//
// Purpose: mode encodings seen on the state output, plus the system tick
//          rate from which the default long-press length is derived.
// Ports:   none (package).
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_e;

   // System tick rate in Hz; one second of hold is one tick-rate worth of edges.
   localparam int unsigned TICK_HZ = 100;

   localparam int unsigned HOLD_TICKS_DEFAULT = TICK_HZ;
   localparam int unsigned HOLD_W_DEFAULT     = 7;

endpackage

// File: rtl/long_press.sv
// rtl/long_press.sv - saturating hold counter that flags the edge completing a long press
//
// Purpose: counts consecutive clock edges on which en and level are both
//          high. fire is combinational and is high on the edge that would
//          complete the HOLD_TICKS-th consecutive high sample.
// Ports:
//   clk_100hz  in  system tick clock
//   rst        in  asynchronous active-low reset
//   en         in  counting allowed (owner is in its pause mode)
//   level      in  debounced button level
//   fire       out this edge is the qualifying long-press edge
module long_press #(
   parameter int HOLD_TICKS = 100,
   parameter int HOLD_W     = 7
) (
   input  logic clk_100hz,
   input  logic rst,
   input  logic en,
   input  logic level,
   output logic fire
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] FIRE_AT  = HOLD_W'(HOLD_TICKS - 1);

   logic [HOLD_W-1:0] h_q;
   logic [HOLD_W-1:0] h_d;

   always_comb begin
      h_d = '0;
      if (en && level) begin
         h_d = (h_q == HOLD_MAX) ? h_q : h_q + 1'b1;
      end
   end

   always_ff @(posedge clk_100hz or negedge rst) begin
      if (!rst) begin
         h_q <= '0;
      end else begin
         h_q <= h_d;
      end
   end

   // h_q counts edges already seen, so the HOLD_TICKS-th edge is when h_q == HOLD_TICKS-1.
   assign fire = en && level && (h_q == FIRE_AT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM with lap freeze and long-press clear
//
// Purpose: decodes start/stop and lap/reset one-pulse streams into the
//          idle/run/pause/lap modes and issues a one-cycle clear to the
//          counters when lap is held long enough in pause.
// Ports:
//   clk_100hz    in   system tick clock
//   rst          in   asynchronous active-low reset
//   start_pulse  in   start/stop one-pulse
//   lap_pulse    in   lap/reset one-pulse
//   lap_level    in   debounced lap/reset level
//   state        out  current mode (IDLE/RUN/PAUSE/LAP)
//   count_en     out  counter enable (RUN or LAP)
//   freeze       out  display latch hold (LAP)
//   clear        out  one-cycle counter clear, first cycle of IDLE after a long press
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT,
   parameter int HOLD_W     = HOLD_W_DEFAULT
) (
   input  logic       clk_100hz,
   input  logic       rst,
   input  logic       start_pulse,
   input  logic       lap_pulse,
   input  logic       lap_level,
   output logic [1:0] state,
   output logic       count_en,
   output logic       freeze,
   output logic       clear
);

   sw_state_e state_q, state_d;
   logic      count_en_q, count_en_d;
   logic      freeze_q, freeze_d;
   logic      clear_q, clear_d;
   logic      hold_fire;

   long_press #(
      .HOLD_TICKS (HOLD_TICKS),
      .HOLD_W     (HOLD_W)
   ) u_long_press (
      .clk_100hz (clk_100hz),
      .rst       (rst),
      .en        (state_q == ST_PAUSE),
      .level     (lap_level),
      .fire      (hold_fire)
   );

   // start_pulse is tested first in every mode, so it wins over a simultaneous
   // lap_pulse and over a long press completing on the same edge.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_pulse) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (start_pulse)    state_d = ST_PAUSE;
            else if (lap_pulse) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (start_pulse)    state_d = ST_PAUSE;
            else if (lap_pulse) state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (start_pulse) begin
               state_d = ST_RUN;
            end else if (hold_fire) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Outputs are decoded from the next state and registered, so they change
      // on the same edge as the mode with no extra latency.
      count_en_d = (state_d == ST_RUN) || (state_d == ST_LAP);
      freeze_d   = (state_d == ST_LAP);
   end

   always_ff @(posedge clk_100hz or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         count_en_q <= 1'b0;
         freeze_q   <= 1'b0;
         clear_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_en_q <= count_en_d;
         freeze_q   <= freeze_d;
         clear_q    <= clear_d;
      end
   end

   assign state    = state_q;
   assign count_en = count_en_q;
   assign freeze   = freeze_q;
   assign clear    = clear_q;

endmodule
